// File: rtl/crc32_stream_gen_if.sv
// -----------------------------------------------------------------------------
// crc32_stream_gen_if
// Purpose : Bundles the beat-input and result-output handshakes of the
//           streaming CRC engine.
// Signals : data_i/valid_i/sop_i/eop_i  beat stream into the engine
//           ready_o                     engine can accept a beat
//           crc_o/crc_valid_o           finished checksum and its valid flag
//           crc_ready_i                 consumer takes the checksum
//           seq_err_o                   one-cycle framing-violation pulse
// Modports: slave  - the CRC engine
//           master - the producer/consumer side around it
// -----------------------------------------------------------------------------
interface crc32_stream_gen_if #(
  parameter int DATA_WIDTH = 512,
  parameter int CRC_WIDTH  = 32
);
  logic [DATA_WIDTH-1:0] data_i;
  logic                  valid_i;
  logic                  sop_i;
  logic                  eop_i;
  logic                  ready_o;
  logic [CRC_WIDTH-1:0]  crc_o;
  logic                  crc_valid_o;
  logic                  crc_ready_i;
  logic                  seq_err_o;

  modport slave (
    input  data_i, valid_i, sop_i, eop_i, crc_ready_i,
    output ready_o, crc_o, crc_valid_o, seq_err_o
  );

  modport master (
    output data_i, valid_i, sop_i, eop_i, crc_ready_i,
    input  ready_o, crc_o, crc_valid_o, seq_err_o
  );
endinterface

// File: rtl/crc32_stream_gen.sv
// -----------------------------------------------------------------------------
// crc32_stream_gen
// Purpose : Streaming CRC engine. Accumulates a CRC over a multi-beat frame
//           delimited by sop/eop and presents the result on a valid/ready
//           handshake. Polynomial, preset, final XOR and reflections are
//           elaboration-time parameters. One frame in flight at a time.
// Ports   : clk    rising-edge clock
//           rst_n  synchronous active-low reset
//           bus    crc32_stream_gen_if.slave (beat stream in, CRC out)
// -----------------------------------------------------------------------------
module crc32_stream_gen #(
  parameter int          DATA_WIDTH  = 512,
  parameter int          CRC_WIDTH   = 32,
  parameter logic [31:0] GEN_POLY    = 32'h000000AF,
  parameter logic [31:0] INIT_VAL    = 32'h00000000,
  parameter logic [31:0] XOR_OUT     = 32'h00000000,
  parameter bit          REFLECT_IN  = 1'b0,
  parameter bit          REFLECT_OUT = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  crc32_stream_gen_if.slave   bus
);

  localparam int                   NUM_BYTES = DATA_WIDTH / 8;
  localparam logic [CRC_WIDTH-1:0] POLY      = GEN_POLY[CRC_WIDTH-1:0];
  localparam logic [CRC_WIDTH-1:0] INIT      = INIT_VAL[CRC_WIDTH-1:0];
  localparam logic [CRC_WIDTH-1:0] XORV      = XOR_OUT[CRC_WIDTH-1:0];

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                r_state, w_state_next;
  logic [CRC_WIDTH-1:0]  r_crc, w_crc_next;
  logic [CRC_WIDTH-1:0]  r_crc_out, w_crc_out_next;
  logic                  r_crc_valid, w_crc_valid_next;
  logic                  r_seq_err, w_seq_err_next;
  logic [CRC_WIDTH-1:0]  w_crc_base, w_crc_upd, w_crc_rev;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_ready, w_accept;

  // Optional per-byte bit reversal of the incoming beat.
  genvar gi, gj;
  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_byte
      for (gj = 0; gj < 8; gj++) begin : g_bit
        assign w_data[gi*8+gj] = REFLECT_IN ? bus.data_i[gi*8+7-gj]
                                            : bus.data_i[gi*8+gj];
      end
    end
    for (gi = 0; gi < CRC_WIDTH; gi++) begin : g_rev
      assign w_crc_rev[gi] = w_crc_upd[CRC_WIDTH-1-gi];
    end
  endgenerate

  assign w_ready  = (r_state != ST_DONE);
  assign w_accept = bus.valid_i && w_ready;

  // A sop always restarts from the preset, even mid-frame.
  assign w_crc_base = (r_state == ST_ACCUM && !bus.sop_i) ? r_crc : INIT;

  // Bit-serial LFSR unrolled over the whole beat, MSB first.
  always_comb begin
    w_crc_upd = w_crc_base;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (w_crc_upd[CRC_WIDTH-1] ^ w_data[i])
        w_crc_upd = {w_crc_upd[CRC_WIDTH-2:0], 1'b0} ^ POLY;
      else
        w_crc_upd = {w_crc_upd[CRC_WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_crc_next       = r_crc;
    w_crc_out_next   = r_crc_out;
    w_crc_valid_next = r_crc_valid;
    w_seq_err_next   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (bus.sop_i) begin
            w_crc_next   = w_crc_upd;
            w_state_next = bus.eop_i ? ST_DONE : ST_ACCUM;
          end else begin
            // Beat outside a frame is dropped.
            w_seq_err_next = 1'b1;
          end
        end
      end
      ST_ACCUM: begin
        if (w_accept) begin
          w_crc_next     = w_crc_upd;
          w_seq_err_next = bus.sop_i;
          if (bus.eop_i) w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (r_crc_valid && bus.crc_ready_i) begin
          w_crc_valid_next = 1'b0;
          w_state_next     = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    // Result is captured on the edge that accepts the eop beat.
    if (w_state_next == ST_DONE && r_state != ST_DONE) begin
      w_crc_out_next   = (REFLECT_OUT ? w_crc_rev : w_crc_upd) ^ XORV;
      w_crc_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_crc       <= INIT;
      r_crc_out   <= '0;
      r_crc_valid <= 1'b0;
      r_seq_err   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_crc       <= w_crc_next;
      r_crc_out   <= w_crc_out_next;
      r_crc_valid <= w_crc_valid_next;
      r_seq_err   <= w_seq_err_next;
    end
  end

  assign bus.ready_o     = w_ready;
  assign bus.crc_o       = r_crc_out;
  assign bus.crc_valid_o = r_crc_valid;
  assign bus.seq_err_o   = r_seq_err;

endmodule

// File: tb/tb_crc32_stream_gen.sv
// -----------------------------------------------------------------------------
// tb_crc32_stream_gen
// Three engines: A = CRC-32/XFER (8-bit beats), B = reflected CRC-32 (8-bit
// beats, same stimulus as A), C = defaults with 512-bit beats.
// -----------------------------------------------------------------------------
module tb_crc32_stream_gen;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [7:0]   d8;
  logic [511:0] d512;
  logic         v, vc, sop, eop, crdy;

  int vectors    = 0;
  int miscompares = 0;

  logic [7:0] msg_q[$];

  crc32_stream_gen_if #(.DATA_WIDTH(8),   .CRC_WIDTH(32)) if_a ();
  crc32_stream_gen_if #(.DATA_WIDTH(8),   .CRC_WIDTH(32)) if_b ();
  crc32_stream_gen_if #(.DATA_WIDTH(512), .CRC_WIDTH(32)) if_c ();

  assign if_a.data_i      = d8;
  assign if_a.valid_i     = v;
  assign if_a.sop_i       = sop;
  assign if_a.eop_i       = eop;
  assign if_a.crc_ready_i = crdy;
  assign if_b.data_i      = d8;
  assign if_b.valid_i     = v;
  assign if_b.sop_i       = sop;
  assign if_b.eop_i       = eop;
  assign if_b.crc_ready_i = crdy;
  assign if_c.data_i      = d512;
  assign if_c.valid_i     = vc;
  assign if_c.sop_i       = sop;
  assign if_c.eop_i       = eop;
  assign if_c.crc_ready_i = crdy;

  crc32_stream_gen #(.DATA_WIDTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a.slave)
  );

  crc32_stream_gen #(
    .DATA_WIDTH(8), .GEN_POLY(32'h04C11DB7), .INIT_VAL(32'hFFFFFFFF),
    .XOR_OUT(32'hFFFFFFFF), .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b.slave)
  );

  crc32_stream_gen dut_c (
    .clk(clk), .rst_n(rst_n), .bus(if_c.slave)
  );

  // Textbook byte-at-a-time CRC over msg_q.
  function automatic logic [31:0] model(input logic [31:0] poly, input logic [31:0] init,
                                        input logic [31:0] xo, input bit rin, input bit rout);
    logic [31:0] c;
    logic [31:0] r;
    logic [7:0]  b;
    logic [7:0]  br;
    c = init;
    foreach (msg_q[k]) begin
      b = msg_q[k];
      for (int j = 0; j < 8; j++) br[j] = b[7-j];
      if (rin) b = br;
      c = c ^ {b, 24'h000000};
      for (int j = 0; j < 8; j++) c = c[31] ? ((c << 1) ^ poly) : (c << 1);
    end
    for (int j = 0; j < 32; j++) r[j] = c[31-j];
    if (rout) c = r;
    return c ^ xo;
  endfunction

  function automatic logic [31:0] model_a();
    return model(32'h000000AF, 32'h0, 32'h0, 1'b0, 1'b0);
  endfunction

  function automatic logic [31:0] model_b();
    return model(32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_check_msg();
    msg_q = {};
    for (int i = 0; i < 9; i++) msg_q.push_back(8'(8'h31 + i));
  endtask

  task automatic load_rand_msg(input int n);
    msg_q = {};
    for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
  endtask

  // Drives msg_q into engines A and B, one byte per beat.
  task automatic send_frame(input bit gaps, input bit no_eop, input bit err_first);
    int n;
    n = msg_q.size();
    for (int k = 0; k < n; k++) begin
      if (gaps && k > 0 && (k == 4 || $urandom_range(0, 2) == 0)) begin
        v = 1'b0; sop = 1'b0; eop = 1'b0;
        tick();
        chk("gap_valid_a", {31'b0, if_a.crc_valid_o}, 32'd0);
      end
      d8 = msg_q[k]; v = 1'b1; sop = (k == 0); eop = !no_eop && (k == n - 1);
      tick();
      chk("seq_err_a", {31'b0, if_a.seq_err_o}, {31'b0, (k == 0) && err_first});
      chk("seq_err_b", {31'b0, if_b.seq_err_o}, {31'b0, (k == 0) && err_first});
      if (!eop) chk("early_valid_a", {31'b0, if_a.crc_valid_o}, 32'd0);
    end
    v = 1'b0; sop = 1'b0; eop = 1'b0;
    $display("frame len=%0d gaps=%0d no_eop=%0d crc_a=%08h crc_b=%08h",
             n, gaps, no_eop, if_a.crc_o, if_b.crc_o);
  endtask

  task automatic check_result(input string tag, input logic [31:0] exp_a, input logic [31:0] exp_b);
    chk({tag, "_valid_a"}, {31'b0, if_a.crc_valid_o}, 32'd1);
    chk({tag, "_valid_b"}, {31'b0, if_b.crc_valid_o}, 32'd1);
    chk({tag, "_ready_a"}, {31'b0, if_a.ready_o}, 32'd0);
    chk({tag, "_crc_a"}, if_a.crc_o, exp_a);
    chk({tag, "_crc_b"}, if_b.crc_o, exp_b);
  endtask

  task automatic consume();
    crdy = 1'b1;
    tick();
    crdy = 1'b0;
    chk("consume_valid_a", {31'b0, if_a.crc_valid_o}, 32'd0);
    chk("consume_ready_a", {31'b0, if_a.ready_o}, 32'd1);
  endtask

  initial begin
    logic [511:0] beat;
    rst_n = 1'b0; d8 = '0; d512 = '0; v = 1'b0; vc = 1'b0;
    sop = 1'b0; eop = 1'b0; crdy = 1'b0;
    tick();
    tick();
    chk("rst_ready_a", {31'b0, if_a.ready_o}, 32'd1);
    chk("rst_valid_a", {31'b0, if_a.crc_valid_o}, 32'd0);
    chk("rst_crc_a", if_a.crc_o, 32'd0);
    chk("rst_seq_err_a", {31'b0, if_a.seq_err_o}, 32'd0);
    chk("rst_valid_c", {31'b0, if_c.crc_valid_o}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Check string, contiguous and with gaps.
    load_check_msg();
    send_frame(1'b0, 1'b0, 1'b0);
    check_result("check", 32'hBD0BE338, 32'hCBF43926);
    chk("check_model_a", model_a(), 32'hBD0BE338);
    chk("check_model_b", model_b(), 32'hCBF43926);
    consume();
    send_frame(1'b1, 1'b0, 1'b0);
    check_result("gaps", 32'hBD0BE338, 32'hCBF43926);
    consume();

    // Random frames.
    for (int f = 0; f < 4; f++) begin
      load_rand_msg(int'($urandom_range(1, 12)));
      send_frame(f[0], 1'b0, 1'b0);
      check_result("rand", model_a(), model_b());
      consume();
    end

    // Backpressure: result held, beats refused.
    load_check_msg();
    send_frame(1'b0, 1'b0, 1'b0);
    check_result("bp0", 32'hBD0BE338, 32'hCBF43926);
    for (int i = 0; i < 5; i++) begin
      d8 = 8'($urandom); v = 1'b1; sop = 1'b1; eop = 1'b1; crdy = 1'b0;
      tick();
      check_result("bp_hold", 32'hBD0BE338, 32'hCBF43926);
      chk("bp_seq_err_a", {31'b0, if_a.seq_err_o}, 32'd0);
    end
    v = 1'b0; sop = 1'b0; eop = 1'b0;
    consume();
    load_rand_msg(5);
    send_frame(1'b0, 1'b0, 1'b0);
    check_result("after_bp", model_a(), model_b());
    consume();

    // Beat without sop in IDLE.
    d8 = 8'h5A; v = 1'b1; sop = 1'b0; eop = 1'b1;
    tick();
    v = 1'b0; eop = 1'b0;
    chk("nosop_err_a", {31'b0, if_a.seq_err_o}, 32'd1);
    chk("nosop_valid_a", {31'b0, if_a.crc_valid_o}, 32'd0);
    tick();
    chk("nosop_err_clr_a", {31'b0, if_a.seq_err_o}, 32'd0);
    chk("nosop_noresult_a", {31'b0, if_a.crc_valid_o}, 32'd0);

    // sop in the middle of a frame restarts the CRC.
    load_rand_msg(3);
    send_frame(1'b0, 1'b1, 1'b0);
    load_check_msg();
    send_frame(1'b0, 1'b0, 1'b1);
    check_result("restart", 32'hBD0BE338, 32'hCBF43926);
    consume();

    // Reset mid-frame, inputs ignored during reset.
    load_rand_msg(4);
    send_frame(1'b0, 1'b1, 1'b0);
    rst_n = 1'b0; d8 = 8'h55; v = 1'b1; sop = 1'b1; eop = 1'b1;
    tick();
    rst_n = 1'b1; v = 1'b0; sop = 1'b0; eop = 1'b0;
    tick();
    chk("rstmid_valid_a", {31'b0, if_a.crc_valid_o}, 32'd0);
    chk("rstmid_ready_a", {31'b0, if_a.ready_o}, 32'd1);
    chk("rstmid_seq_err_a", {31'b0, if_a.seq_err_o}, 32'd0);

    // Reset while holding a result.
    load_check_msg();
    send_frame(1'b0, 1'b0, 1'b0);
    check_result("pre_rst", 32'hBD0BE338, 32'hCBF43926);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("rstdone_valid_a", {31'b0, if_a.crc_valid_o}, 32'd0);
    chk("rstdone_ready_a", {31'b0, if_a.ready_o}, 32'd1);
    chk("rstdone_crc_a", if_a.crc_o, 32'd0);
    send_frame(1'b0, 1'b0, 1'b0);
    check_result("post_rst", 32'hBD0BE338, 32'hCBF43926);
    consume();

    // 512-bit engine: all-zero beat, random beat, two-beat frame.
    d512 = '0; vc = 1'b1; sop = 1'b1; eop = 1'b1;
    tick();
    vc = 1'b0; sop = 1'b0; eop = 1'b0;
    chk("w512_zero_valid", {31'b0, if_c.crc_valid_o}, 32'd1);
    chk("w512_zero_crc", if_c.crc_o, 32'd0);
    $display("w512 zero crc_c=%08h", if_c.crc_o);
    crdy = 1'b1; tick(); crdy = 1'b0;
    chk("w512_consume", {31'b0, if_c.crc_valid_o}, 32'd0);

    for (int f = 0; f < 2; f++) begin
      msg_q = {};
      for (int b = 0; b <= f; b++) begin
        for (int w = 0; w < 16; w++) beat[w*32 +: 32] = $urandom;
        for (int i = 63; i >= 0; i--) msg_q.push_back(beat[i*8 +: 8]);
        d512 = beat; vc = 1'b1; sop = (b == 0); eop = (b == f);
        tick();
      end
      vc = 1'b0; sop = 1'b0; eop = 1'b0;
      chk("w512_rand_valid", {31'b0, if_c.crc_valid_o}, 32'd1);
      chk("w512_rand_crc", if_c.crc_o, model_a());
      $display("w512 beats=%0d crc_c=%08h", f + 1, if_c.crc_o);
      crdy = 1'b1; tick(); crdy = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
